// File: rtl/counter_timer_if.sv
// counter_timer_if
//   Groups the control, data and status signals of counter_timer into one bundle.
//   The master side (the block that owns the timer) drives the controls and
//   reads the status; the slave side is the counter itself.
//
//   Signals
//     start      1-cycle pulse: arm the counter
//     stop       1-cycle pulse: halt the counter, count held
//     load       load count and reload register from load_data
//     load_data  DW-bit load value
//     tc_value   DW-bit terminal value (increment direction only)
//     periodic   0 = one-shot, 1 = auto-reload
//     in         count strobe
//     count      DW-bit current count
//     carry      1-cycle pulse: carry/borrow out of the DW-bit count
//     zero       count == 0
//     busy       counter is running
//     done       1-cycle pulse at terminal count
interface counter_timer_if #(
    parameter int DW = 32
) ();
    logic          start;
    logic          stop;
    logic          load;
    logic [DW-1:0] load_data;
    logic [DW-1:0] tc_value;
    logic          periodic;
    logic          in;
    logic [DW-1:0] count;
    logic          carry;
    logic          zero;
    logic          busy;
    logic          done;

    modport master (
        output start, stop, load, load_data, tc_value, periodic, in,
        input  count, carry, zero, busy, done
    );

    modport slave (
        input  start, stop, load, load_data, tc_value, periodic, in,
        output count, carry, zero, busy, done
    );
endinterface

// File: rtl/counter_timer.sv
// counter_timer
//   Up/down event counter with an IDLE/RUN/DONE control FSM, terminal-count
//   detection and one-shot or periodic (auto-reload) operation.
//
//   Parameters
//     DW    counter, load and terminal-value width
//     TYPE  "INCREMENT" or "DECREMENT"
//     PSW   prescaler width (only used when COUNTER_PRESCALE_EN is defined)
//
//   Ports
//     clk       clock, all state changes on the rising edge
//     nreset    asynchronous active-low reset
//     prescale  PSW-bit strobe divider setting (COUNTER_PRESCALE_EN only)
//     bus       counter_timer_if slave modport (controls in, status out)
//
//   Build option
//     COUNTER_PRESCALE_EN  adds the prescale port; a count step then happens
//                          only on every (prescale+1)th qualifying strobe.
module counter_timer #(
    parameter int    DW   = 32,
    parameter string TYPE = "INCREMENT",
    parameter int    PSW  = 8
) (
    input  logic clk,
    input  logic nreset,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PSW-1:0] prescale,
`endif
    counter_timer_if.slave bus
);

    localparam bit IS_DEC = (TYPE == "DECREMENT");

    // Catch nonsensical configurations at elaboration time.
    if (PSW < 1 || DW < 1 || !(TYPE == "INCREMENT" || TYPE == "DECREMENT")) begin : g_bad_cfg
        $error("counter_timer: invalid DW/PSW/TYPE configuration");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [DW-1:0] count_q, count_next;
    logic [DW-1:0] reload_q, reload_next;
    logic [DW-1:0] init_val;
    logic [DW-1:0] term_val;
    logic [DW:0]   stepped;
    logic          carry_q, carry_next;
    logic          done_q, done_next;
    logic          qualified;
    logic          step;
    logic          terminal;

    // Step arithmetic is one bit wider so the top bit is the carry/borrow.
    // A decrement from zero is also treated as terminal, so a zero reload in
    // periodic mode fires done on every step instead of wrapping to all-ones.
    always_comb begin
        init_val = IS_DEC ? reload_q : '0;
        term_val = IS_DEC ? '0 : bus.tc_value;
        if (IS_DEC) begin
            stepped  = {1'b0, count_q} - {{DW{1'b0}}, 1'b1};
            terminal = (stepped[DW-1:0] == '0) || (count_q == '0);
        end else begin
            stepped  = {1'b0, count_q} + {{DW{1'b0}}, 1'b1};
            terminal = (stepped[DW-1:0] == bus.tc_value);
        end
        qualified = (state == RUN) && bus.in && !bus.load && !bus.stop;
    end

`ifdef COUNTER_PRESCALE_EN
    logic [PSW-1:0] div_q, div_next;

    // Divider restarts on any load/start/stop pulse and after every step.
    always_comb begin
        step     = qualified && (div_q == prescale);
        div_next = div_q;
        if (bus.load || bus.start || bus.stop) begin
            div_next = '0;
        end else if (qualified) begin
            div_next = step ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_q <= '0;
        end else begin
            div_q <= div_next;
        end
    end
`else
    assign step = qualified;
`endif

    // Load overrides the count but leaves stop/start free to move the FSM.
    // Start only arms from IDLE/DONE; in RUN it is ignored, so a step may
    // still happen in that cycle.
    always_comb begin
        state_next  = state;
        count_next  = count_q;
        reload_next = reload_q;
        carry_next  = 1'b0;
        done_next   = 1'b0;

        if (bus.load) begin
            count_next  = bus.load_data;
            reload_next = bus.load_data;
        end

        if (bus.stop) begin
            if (state == RUN) begin
                state_next = IDLE;
            end
        end else if (bus.start && state != RUN) begin
            state_next = RUN;
            if (!bus.load) begin
                count_next = init_val;
            end
        end

        if (step) begin
            carry_next = stepped[DW];
            if (terminal) begin
                done_next = 1'b1;
                if (bus.periodic) begin
                    count_next = init_val;
                end else begin
                    count_next = term_val;
                    state_next = DONE;
                end
            end else begin
                count_next = stepped[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            count_q  <= count_next;
            reload_q <= reload_next;
            carry_q  <= carry_next;
            done_q   <= done_next;
        end
    end

    assign bus.count = count_q;
    assign bus.carry = carry_q;
    assign bus.zero  = (count_q == '0);
    assign bus.busy  = (state == RUN);
    assign bus.done  = done_q;

endmodule

// File: tb/tb_counter_timer.sv
// tb_counter_timer
//   Drives three counter_timer instances (8-bit up, 8-bit down, 4-bit up) from
//   one shared stimulus stream and checks them every cycle against an
//   arithmetic reference model, plus hand-computed directed scenarios.
//   With COUNTER_PRESCALE_EN defined the prescale input is exercised as well.
module tb_counter_timer;

    logic       clk;
    logic       nreset;
    logic       s_start, s_stop, s_load, s_periodic, s_in;
    logic [7:0] s_ld, s_tc, s_ps;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       running;
        logic [7:0] count;
        logic [7:0] reload;
        logic       carry;
        logic       done;
        logic [7:0] div;
    } model_t;

    model_t m_inc8, m_dec8, m_inc4;

    counter_timer_if #(.DW(8)) b_inc8 ();
    counter_timer_if #(.DW(8)) b_dec8 ();
    counter_timer_if #(.DW(4)) b_inc4 ();

    assign b_inc8.start = s_start;  assign b_dec8.start = s_start;  assign b_inc4.start = s_start;
    assign b_inc8.stop  = s_stop;   assign b_dec8.stop  = s_stop;   assign b_inc4.stop  = s_stop;
    assign b_inc8.load  = s_load;   assign b_dec8.load  = s_load;   assign b_inc4.load  = s_load;
    assign b_inc8.periodic = s_periodic;
    assign b_dec8.periodic = s_periodic;
    assign b_inc4.periodic = s_periodic;
    assign b_inc8.in = s_in;        assign b_dec8.in = s_in;        assign b_inc4.in = s_in;
    assign b_inc8.load_data = s_ld;
    assign b_dec8.load_data = s_ld;
    assign b_inc4.load_data = s_ld[3:0];
    assign b_inc8.tc_value  = s_tc;
    assign b_dec8.tc_value  = s_tc;
    assign b_inc4.tc_value  = s_tc[3:0];

    counter_timer #(.DW(8), .TYPE("INCREMENT"), .PSW(8)) u_inc8 (
        .clk(clk), .nreset(nreset),
`ifdef COUNTER_PRESCALE_EN
        .prescale(s_ps),
`endif
        .bus(b_inc8.slave)
    );

    counter_timer #(.DW(8), .TYPE("DECREMENT"), .PSW(8)) u_dec8 (
        .clk(clk), .nreset(nreset),
`ifdef COUNTER_PRESCALE_EN
        .prescale(s_ps),
`endif
        .bus(b_dec8.slave)
    );

    counter_timer #(.DW(4), .TYPE("INCREMENT"), .PSW(8)) u_inc4 (
        .clk(clk), .nreset(nreset),
`ifdef COUNTER_PRESCALE_EN
        .prescale(s_ps),
`endif
        .bus(b_inc4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff_ps();
`ifdef COUNTER_PRESCALE_EN
        return int'(s_ps);
`else
        return 0;
`endif
    endfunction

    // Reference: what one clock edge does to a counter of width dw, written
    // with plain integer arithmetic on the current stimulus.
    function automatic model_t model_next(model_t m, int dw, bit dec, int ps);
        model_t n     = m;
        longint mask  = (longint'(1) << dw) - 1;
        longint tc    = longint'(s_tc) & mask;
        longint raw;
        bit     qual, stp, hit;
        n.carry = 1'b0;
        n.done  = 1'b0;
        qual = m.running && s_in && !s_load && !s_stop;
        stp  = qual && (int'(m.div) == ps);
        if (s_load || s_start || s_stop) n.div = 8'd0;
        else if (qual) n.div = stp ? 8'd0 : m.div + 8'd1;
        if (s_load) begin
            n.count  = 8'(longint'(s_ld) & mask);
            n.reload = 8'(longint'(s_ld) & mask);
        end
        if (s_stop) begin
            n.running = 1'b0;
        end else if (s_start && !m.running) begin
            n.running = 1'b1;
            if (!s_load) n.count = dec ? m.reload : 8'd0;
        end
        if (stp) begin
            raw     = dec ? longint'(m.count) - 1 : longint'(m.count) + 1;
            n.carry = (raw < 0) || (raw > mask);
            hit     = dec ? (raw <= 0) : ((raw & mask) == tc);
            if (hit) begin
                n.done = 1'b1;
                if (s_periodic) begin
                    n.count = dec ? m.reload : 8'd0;
                end else begin
                    n.count   = dec ? 8'd0 : 8'(tc);
                    n.running = 1'b0;
                end
            end else begin
                n.count = 8'(raw & mask);
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_inc8 <= '0;
            m_dec8 <= '0;
            m_inc4 <= '0;
        end else begin
            m_inc8 <= model_next(m_inc8, 8, 1'b0, eff_ps());
            m_dec8 <= model_next(m_dec8, 8, 1'b1, eff_ps());
            m_inc4 <= model_next(m_inc4, 4, 1'b0, eff_ps());
        end
    end

    task automatic check_output(input string what, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", what, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string name, input logic [7:0] cnt, input logic carry,
                             input logic zero, input logic busy, input logic done, input model_t m);
        check_output({name, " count"}, 32'(cnt), 32'(m.count));
        check_output({name, " carry"}, 32'(carry), 32'(m.carry));
        check_output({name, " zero"}, 32'(zero), 32'(m.count == 8'd0));
        check_output({name, " busy"}, 32'(busy), 32'(m.running));
        check_output({name, " done"}, 32'(done), 32'(m.done));
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (nreset === 1'b1) begin
            check_dut("inc8", b_inc8.count, b_inc8.carry, b_inc8.zero, b_inc8.busy, b_inc8.done, m_inc8);
            check_dut("dec8", b_dec8.count, b_dec8.carry, b_dec8.zero, b_dec8.busy, b_dec8.done, m_dec8);
            check_dut("inc4", 8'(b_inc4.count), b_inc4.carry, b_inc4.zero, b_inc4.busy, b_inc4.done, m_inc4);
        end
    end

    task automatic apply_stimulus(input bit st, input bit sp, input bit ld_en, input bit per,
                                  input bit inn, input logic [7:0] ld, input logic [7:0] tc);
        @(negedge clk);
        s_start    = st;
        s_stop     = sp;
        s_load     = ld_en;
        s_periodic = per;
        s_in       = inn;
        s_ld       = ld;
        s_tc       = tc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        s_start = 0; s_stop = 0; s_load = 0; s_periodic = 0; s_in = 0;
        s_ld = 8'd0; s_tc = 8'd0; s_ps = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_cnt[5];
        int done_seen;
        exp_cnt = '{1, 2, 3, 3, 3};

        do_reset();
        #1;
        check_output("reset inc8 count", 32'(b_inc8.count), 32'd0);
        check_output("reset inc8 busy", 32'(b_inc8.busy), 32'd0);
        check_output("reset inc8 zero", 32'(b_inc8.zero), 32'd1);

        // Reset while running with count 5.
        apply_stimulus(1, 0, 0, 0, 0, 8'd0, 8'd200);
        check_output("armed inc8 busy", 32'(b_inc8.busy), 32'd1);
        repeat (5) apply_stimulus(0, 0, 0, 0, 1, 8'd0, 8'd200);
        check_output("run inc8 count5", 32'(b_inc8.count), 32'd5);
        @(negedge clk);
        #2;
        nreset = 1'b0;
        #1;
        check_output("async rst count", 32'(b_inc8.count), 32'd0);
        check_output("async rst busy", 32'(b_inc8.busy), 32'd0);
        check_output("async rst done", 32'(b_inc8.done), 32'd0);
        check_output("async rst carry", 32'(b_inc8.carry), 32'd0);
        do_reset();

        // One-shot up counter to 3.
        apply_stimulus(1, 0, 0, 0, 0, 8'd0, 8'd3);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 0, 0, 0, 1, 8'd0, 8'd3);
            check_output("oneshot count", 32'(b_inc8.count), 32'(exp_cnt[i]));
            check_output("oneshot done", 32'(b_inc8.done), 32'(i == 2));
            check_output("oneshot busy", 32'(b_inc8.busy), 32'(i < 2));
        end
        check_output("model oneshot count", 32'(m_inc8.count), 32'd3);

        // Periodic down counter reloading from 2.
        apply_stimulus(0, 1, 0, 0, 0, 8'd0, 8'd3);
        apply_stimulus(0, 0, 1, 1, 0, 8'd2, 8'd3);
        apply_stimulus(1, 0, 0, 1, 0, 8'd2, 8'd3);
        check_output("dec start count", 32'(b_dec8.count), 32'd2);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 0, 0, 1, 1, 8'd2, 8'd3);
            check_output("dec periodic count", 32'(b_dec8.count), (i % 2 == 0) ? 32'd1 : 32'd2);
            check_output("dec periodic busy", 32'(b_dec8.busy), 32'd1);
            done_seen += int'(b_dec8.done);
        end
        check_output("dec done pulses", 32'(done_seen), 32'd3);
        check_output("model dec count", 32'(m_dec8.count), 32'd2);

        // 4-bit: terminal at 15, then wrap to terminal 0 with carry.
        apply_stimulus(0, 1, 0, 0, 0, 8'd0, 8'd15);
        apply_stimulus(1, 0, 1, 0, 0, 8'd14, 8'd15);
        check_output("inc4 loaded", 32'(b_inc4.count), 32'd14);
        apply_stimulus(0, 0, 0, 0, 1, 8'd14, 8'd15);
        check_output("inc4 tc15 count", 32'(b_inc4.count), 32'd15);
        check_output("inc4 tc15 done", 32'(b_inc4.done), 32'd1);
        apply_stimulus(1, 0, 1, 0, 0, 8'd14, 8'd0);
        apply_stimulus(0, 0, 0, 0, 1, 8'd14, 8'd0);
        check_output("inc4 wrap 15", 32'(b_inc4.count), 32'd15);
        check_output("inc4 no carry", 32'(b_inc4.carry), 32'd0);
        apply_stimulus(0, 0, 0, 0, 1, 8'd14, 8'd0);
        check_output("inc4 wrap 0", 32'(b_inc4.count), 32'd0);
        check_output("inc4 wrap carry", 32'(b_inc4.carry), 32'd1);
        check_output("inc4 wrap done", 32'(b_inc4.done), 32'd1);
        apply_stimulus(0, 0, 0, 0, 1, 8'd14, 8'd0);
        check_output("inc4 carry drop", 32'(b_inc4.carry), 32'd0);
        check_output("inc4 held", 32'(b_inc4.count), 32'd0);

        // load + stop + in together while running.
        apply_stimulus(0, 1, 0, 0, 0, 8'd0, 8'd200);
        apply_stimulus(1, 0, 0, 0, 0, 8'd0, 8'd200);
        repeat (2) apply_stimulus(0, 0, 0, 0, 1, 8'd0, 8'd200);
        check_output("pre-load count", 32'(b_inc8.count), 32'd2);
        apply_stimulus(0, 1, 1, 0, 1, 8'd9, 8'd200);
        check_output("load+stop count", 32'(b_inc8.count), 32'd9);
        check_output("load+stop busy", 32'(b_inc8.busy), 32'd0);
        apply_stimulus(0, 0, 0, 0, 1, 8'd9, 8'd200);
        check_output("idle no step", 32'(b_inc8.count), 32'd9);

`ifdef COUNTER_PRESCALE_EN
        apply_stimulus(0, 1, 0, 0, 0, 8'd0, 8'd200);
        s_ps = 8'd2;
        apply_stimulus(1, 0, 0, 0, 0, 8'd0, 8'd200);
        for (int i = 1; i <= 9; i++) begin
            apply_stimulus(0, 0, 0, 0, 1, 8'd0, 8'd200);
            check_output("prescale count", 32'(b_inc8.count), 32'(i / 3));
        end
        s_ps = 8'd0;
`endif

        // Randomised traffic with occasional asynchronous resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clk);
                #2;
                nreset = 1'b0;
                #3;
                nreset = 1'b1;
`ifdef COUNTER_PRESCALE_EN
                s_ps = 8'($urandom_range(0, 3));
`endif
            end
            apply_stimulus($urandom_range(0, 9) == 0,
                           $urandom_range(0, 19) == 0,
                           $urandom_range(0, 15) == 0,
                           ($urandom_range(0, 29) == 0) ? !s_periodic : s_periodic,
                           $urandom_range(0, 3) != 0,
                           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12)),
                           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15)));
        end

        apply_stimulus(0, 0, 0, 0, 0, 8'd0, 8'd0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
